// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: operation modes and FSM states.
package seq_shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single step of the sequential shifter: shifts data by 0..STEP bits.
// Rotate is only built when SEQ_SHIFTER_ROTATE_EN is defined; otherwise ROR acts as SRL.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       mode,
  input  logic             sign,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] ones;
`ifdef SEQ_SHIFTER_ROTATE_EN
  int unsigned lsh;
`endif

  always_comb begin
    ones = '1;
`ifdef SEQ_SHIFTER_ROTATE_EN
    lsh  = WIDTH - int'(k);
`endif
    case (mode)
      MODE_SLL: out = data << k;
      // sign is the operand's original MSB, so every step refills with the same bit
      MODE_SRA: out = (data >> k) | (sign ? ~(ones >> k) : '0);
`ifdef SEQ_SHIFTER_ROTATE_EN
      MODE_ROR: out = (data >> k) | (data << lsh);
`endif
      default:  out = data >> k;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential multi-cycle shifter: shifts up to STEP bits per BUSY cycle until done.
// Optional rotate-right mode is enabled by defining SEQ_SHIFTER_ROTATE_EN.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 8,
  localparam int AW    = $clog2(WIDTH),
  localparam int KW    = $clog2(STEP + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the source holds its payload stable until then, and ready never
  // depends on valid (in_ready and out_valid are functions of state only).

  localparam logic [AW:0] STEP_EXT = (AW + 1)'(STEP);

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_shift;
  logic [AW-1:0]    rem, rem_next;
  logic [1:0]       mode;
  logic             sign;
  logic [KW-1:0]    k;

  always_comb begin
    k        = ({1'b0, rem} < STEP_EXT) ? KW'(rem) : KW'(STEP);
    rem_next = rem - AW'(k);
  end

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
    .data (acc),
    .k    (k),
    .mode (mode),
    .sign (sign),
    .out  (acc_shift)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (rem_next == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc  <= '0;
      rem  <= '0;
      mode <= MODE_SLL;
      sign <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      acc  <= in_data;
      rem  <= in_amt;
      mode <= in_mode;
      sign <= in_data[WIDTH-1];
    end else if (state == BUSY) begin
      acc  <= acc_shift;
      rem  <= rem_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? acc : '0;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=32, STEP=8).
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  m;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9] = '{
    '{32'h80000000, 5'd8,  MODE_SRA, 32'hFF800000, 1},
    '{32'h80000000, 5'd31, MODE_SRL, 32'h00000001, 4},
    '{32'h80000000, 5'd31, MODE_SRA, 32'hFFFFFFFF, 4},
    '{32'h12345678, 5'd0,  MODE_SLL, 32'h12345678, 1},
    '{32'h12345678, 5'd4,  MODE_SLL, 32'h23456780, 1},
    '{32'h7F000000, 5'd20, MODE_SRA, 32'h000007F0, 3},
    '{32'hF0F0F0F0, 5'd16, MODE_SRL, 32'h0000F0F0, 2},
    '{32'h000000FF, 5'd31, MODE_SLL, 32'h80000000, 4},
    '{32'hC0000000, 5'd9,  MODE_SRA, 32'hFFE00000, 2}
  };

  seq_shifter #(.WIDTH(32), .STEP(8)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  // Offers one request at a negedge; returns at the negedge after the accept edge
  // with the inputs scrambled, so any late sampling of them would corrupt the result.
  task automatic start_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom_range(0, 31));
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  // Counts rising edges from accept until out_valid, bounded at 40.
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
  endtask

  task automatic test_idle_hold();
    int moved = 0;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (state_dbg !== IDLE || busy !== 1'b0) moved++;
    end
    checks++;
    if (moved != 0) begin errors++; $display("FAIL idle_hold: left IDLE in %0d cycles, want 0", moved); end
  endtask

  // Back-to-back directed vectors; expected results flow through the scoreboard queue.
  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp;
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);
    foreach (vecs[i]) begin
      start_op(vecs[i].d, vecs[i].a, vecs[i].m);
      wait_result(lat);
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin
        errors++;
        $display("FAIL vec%0d_data: got %h want %h", i, out_data, exp);
      end
      checks++;
      if (lat != vecs[i].lat) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vecs[i].lat);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    start_op(32'h80000000, 5'd8, MODE_SRA);
    wait_result(lat);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      in_amt   = 5'd3;
      in_mode  = MODE_SLL;
      @(negedge clock);
      if (out_valid !== 1'b1 || out_data !== 32'hFF800000 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, want 0", bad); end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL bp_idle: state %0d want %0d", state_dbg, IDLE); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL bp_out_clear: valid %b data %h want 0 0", out_valid, out_data);
    end
    @(negedge clock);
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL bp_no_accept: state %0d want %0d", state_dbg, IDLE); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    int seen = 0;
    start_op(32'h80000000, 5'd31, MODE_SRL);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: busy %b in_ready %b valid %b data %h want 0 1 0 0",
               busy, in_ready, out_valid, out_data);
    end
    @(negedge clock);
    resetn = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_no_result: out_valid seen %0d cycles want 0", seen); end
    start_op(32'h12345678, 5'd4, MODE_SLL);
    wait_result(lat);
    checks++;
    if (out_data !== 32'h23456780 || lat != 1) begin
      errors++;
      $display("FAIL rst_next_req: got %h lat %0d want 23456780 lat 1", out_data, lat);
    end
    release_result();
  endtask

  task automatic test_ror();
    int lat;
    logic [31:0] exp_a, exp_b;
`ifdef SEQ_SHIFTER_ROTATE_EN
    exp_a = 32'h10000000;
    exp_b = 32'h00180000;
`else
    exp_a = 32'h00000000;
    exp_b = 32'h00080000;
`endif
    start_op(32'h00000001, 5'd4, MODE_ROR);
    wait_result(lat);
    checks++;
    if (out_data !== exp_a || lat != 1) begin
      errors++;
      $display("FAIL ror_a: got %h lat %0d want %h lat 1", out_data, lat, exp_a);
    end
    release_result();
    start_op(32'h80000001, 5'd12, MODE_ROR);
    wait_result(lat);
    checks++;
    if (out_data !== exp_b || lat != 2) begin
      errors++;
      $display("FAIL ror_b: got %h lat %0d want %h lat 2", out_data, lat, exp_b);
    end
    release_result();
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    resetn = 1'b1;
    test_idle_hold();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    test_ror();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
